// File: rtl/branch_target_predictor.sv
// ----------------------------------------------------------------------------
// branch_target_predictor
//
// Direct-mapped branch target buffer with saturating direction counters. It
// sits beside the IF-stage program counter and predicts the next fetch address
// every cycle. It is trained by branches and jumps resolved in EX. The same
// block flags EX-stage mispredicts and keeps two saturating statistics
// counters.
//
// Parameters:
//   XLEN     datapath / address width
//   ENTRIES  table entries (power of two, >= 2)
//   CTR_W    direction counter width (>= 2)
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   if_pc                    current fetch address (lookup, combinational)
//   pred_taken, pred_next_pc prediction for the fetch address
//   upd_valid, upd_pc, upd_is_jump, upd_taken, upd_target
//                            resolved branch/jump from EX (training)
//   upd_pred_taken, upd_pred_target
//                            prediction made at fetch, carried down the pipe
//   mispredict, redirect_pc  flush request and correct next PC (combinational)
//   stat_updates             saturating count of upd_valid cycles
//   stat_mispredicts         saturating count of mispredict cycles
// ----------------------------------------------------------------------------
module branch_target_predictor #(
    parameter int XLEN    = 32,
    parameter int ENTRIES = 16,
    parameter int CTR_W   = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] if_pc,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_next_pc,
    input  logic            upd_valid,
    input  logic [XLEN-1:0] upd_pc,
    input  logic            upd_is_jump,
    input  logic            upd_taken,
    input  logic [XLEN-1:0] upd_target,
    input  logic            upd_pred_taken,
    input  logic [XLEN-1:0] upd_pred_target,
    output logic            mispredict,
    output logic [XLEN-1:0] redirect_pc,
    output logic [31:0]     stat_updates,
    output logic [31:0]     stat_mispredicts
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = XLEN - IDX_W - 2;

    localparam logic [CTR_W-1:0] CTR_MAX     = '1;
    localparam logic [CTR_W-1:0] CTR_MIN     = '0;
    localparam logic [CTR_W-1:0] CTR_WEAK_T  = {1'b1, {(CTR_W-1){1'b0}}};
    localparam logic [CTR_W-1:0] CTR_WEAK_NT = {1'b0, {(CTR_W-1){1'b1}}};

    // Table state, one element per entry.
    logic             valid_q  [ENTRIES];
    logic [TAG_W-1:0] tag_q    [ENTRIES];
    logic [XLEN-1:0]  target_q [ENTRIES];
    logic [CTR_W-1:0] ctr_q    [ENTRIES];

    // Address split; pc[1:0] takes no part in indexing or tagging.
    logic [IDX_W-1:0] lk_idx, upd_idx;
    logic [TAG_W-1:0] lk_tag, upd_tag;
    logic             lk_hit, upd_hit;
    logic [CTR_W-1:0] ctr_next;
    logic [3:0]       unused_pc_bits;

    assign lk_idx  = if_pc[IDX_W+1:2];
    assign lk_tag  = if_pc[XLEN-1:IDX_W+2];
    assign upd_idx = upd_pc[IDX_W+1:2];
    assign upd_tag = upd_pc[XLEN-1:IDX_W+2];
    assign unused_pc_bits = {if_pc[1:0], upd_pc[1:0]};

    // ------------------------------------------------------------------
    // Lookup: purely combinational, reads the pre-update table contents.
    // ------------------------------------------------------------------
    assign lk_hit       = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    assign pred_taken   = lk_hit && ctr_q[lk_idx][CTR_W-1];
    assign pred_next_pc = pred_taken ? target_q[lk_idx] : if_pc + XLEN'(4);

    // ------------------------------------------------------------------
    // EX-stage resolution.
    // ------------------------------------------------------------------
    assign mispredict  = upd_valid &&
                         ((upd_pred_taken != upd_taken) ||
                          (upd_taken && (upd_pred_target != upd_target)));
    assign redirect_pc = upd_taken ? upd_target : upd_pc + XLEN'(4);

    assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

    // Counter value written on an update. A miss only writes when taken, so
    // the allocation value is chosen here too.
    // NOTE: every always_comb output gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        ctr_next = ctr_q[upd_idx];
        if (!upd_hit) begin
            ctr_next = upd_is_jump ? CTR_MAX : CTR_WEAK_T;
        end else if (upd_is_jump) begin
            ctr_next = CTR_MAX;
        end else if (upd_taken) begin
            if (ctr_q[upd_idx] != CTR_MAX) ctr_next = ctr_q[upd_idx] + 1'b1;
        end else begin
            if (ctr_q[upd_idx] != CTR_MIN) ctr_next = ctr_q[upd_idx] - 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Training and statistics. Reset wins over a same-cycle update.
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the table is small and every entry's valid bit and
            // counter has a defined reset value, so it is built from
            // resettable flops rather than a RAM macro.
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= CTR_WEAK_NT;
            end
            stat_updates     <= '0;
            stat_mispredicts <= '0;
        end else begin
            if (upd_valid) begin
                if (upd_hit) begin
                    ctr_q[upd_idx] <= ctr_next;
                    if (upd_taken) target_q[upd_idx] <= upd_target;
                end else if (upd_taken) begin
                    valid_q[upd_idx]  <= 1'b1;
                    tag_q[upd_idx]    <= upd_tag;
                    target_q[upd_idx] <= upd_target;
                    ctr_q[upd_idx]    <= ctr_next;
                end
                if (stat_updates != 32'hFFFF_FFFF)
                    stat_updates <= stat_updates + 32'd1;
            end
            if (mispredict && (stat_mispredicts != 32'hFFFF_FFFF))
                stat_mispredicts <= stat_mispredicts + 32'd1;
        end
    end

endmodule

// File: tb/tb_branch_target_predictor.sv
// ----------------------------------------------------------------------------
// tb_branch_target_predictor
//
// Self-checking bench for branch_target_predictor (XLEN=32, ENTRIES=16,
// CTR_W=2). A directed vector table walks through reset, allocation,
// hysteresis, aliasing, jumps, counter floor and reset-over-update. A random
// phase then compares every output against a table model kept in plain
// arrays and integer arithmetic.
// ----------------------------------------------------------------------------
module tb_branch_target_predictor;

    localparam int XLEN    = 32;
    localparam int ENTRIES = 16;
    localparam int CTR_W   = 2;
    localparam int CTR_TOP = (1 << CTR_W) - 1;
    localparam int CTR_HALF = 1 << (CTR_W - 1);

    logic            clk = 1'b0;
    logic            rst;
    logic [XLEN-1:0] if_pc;
    logic            pred_taken;
    logic [XLEN-1:0] pred_next_pc;
    logic            upd_valid;
    logic [XLEN-1:0] upd_pc;
    logic            upd_is_jump;
    logic            upd_taken;
    logic [XLEN-1:0] upd_target;
    logic            upd_pred_taken;
    logic [XLEN-1:0] upd_pred_target;
    logic            mispredict;
    logic [XLEN-1:0] redirect_pc;
    logic [31:0]     stat_updates;
    logic [31:0]     stat_mispredicts;

    int n_checks = 0;
    int n_fail   = 0;

    branch_target_predictor #(
        .XLEN(XLEN), .ENTRIES(ENTRIES), .CTR_W(CTR_W)
    ) dut (
        .clk(clk), .rst(rst),
        .if_pc(if_pc), .pred_taken(pred_taken), .pred_next_pc(pred_next_pc),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_is_jump(upd_is_jump),
        .upd_taken(upd_taken), .upd_target(upd_target),
        .upd_pred_taken(upd_pred_taken), .upd_pred_target(upd_pred_target),
        .mispredict(mispredict), .redirect_pc(redirect_pc),
        .stat_updates(stat_updates), .stat_mispredicts(stat_mispredicts)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] actual,
                         input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)",
                     name, actual, expected, $time);
        end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        rst;
        logic [31:0] if_pc;
        logic        uv;
        logic [31:0] upc;
        logic        jmp;
        logic        tk;
        logic [31:0] tgt;
        logic        ppt;
        logic [31:0] pptg;
        logic        e_pt;
        logic [31:0] e_npc;
        logic        e_mp;
        logic [31:0] e_rd;
        logic [31:0] e_su;
        logic [31:0] e_sm;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic [31:0] ipc, input logic uv,
                       input logic [31:0] upc, input logic jmp, input logic tk,
                       input logic [31:0] tgt, input logic ppt,
                       input logic [31:0] pptg, input logic e_pt,
                       input logic [31:0] e_npc, input logic e_mp,
                       input logic [31:0] e_rd, input logic [31:0] e_su,
                       input logic [31:0] e_sm);
        vec_t v;
        v.rst = r; v.if_pc = ipc; v.uv = uv; v.upc = upc; v.jmp = jmp;
        v.tk = tk; v.tgt = tgt; v.ppt = ppt; v.pptg = pptg;
        v.e_pt = e_pt; v.e_npc = e_npc; v.e_mp = e_mp; v.e_rd = e_rd;
        v.e_su = e_su; v.e_sm = e_sm;
        vecs.push_back(v);
    endtask

    task automatic idle_inputs();
        rst = 1'b0; upd_valid = 1'b0; upd_pc = '0; upd_is_jump = 1'b0;
        upd_taken = 1'b0; upd_target = '0; upd_pred_taken = 1'b0;
        upd_pred_target = '0;
    endtask

    // ---------------- behavioural reference model ----------------
    bit          m_valid  [ENTRIES];
    int unsigned m_tag    [ENTRIES];
    logic [31:0] m_target [ENTRIES];
    int          m_ctr    [ENTRIES];
    longint      m_upd, m_mis;

    function automatic int unsigned idx_of(input logic [31:0] pc);
        return (pc / 4) % ENTRIES;
    endfunction

    function automatic int unsigned tag_of(input logic [31:0] pc);
        return pc / (4 * ENTRIES);
    endfunction

    function automatic bit m_hit(input logic [31:0] pc);
        return m_valid[idx_of(pc)] && (m_tag[idx_of(pc)] == tag_of(pc));
    endfunction

    function automatic bit m_pred_taken(input logic [31:0] pc);
        return m_hit(pc) && (m_ctr[idx_of(pc)] >= CTR_HALF);
    endfunction

    function automatic logic [31:0] m_pred_pc(input logic [31:0] pc);
        return m_pred_taken(pc) ? m_target[idx_of(pc)] : pc + 32'd4;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < ENTRIES; i++) begin
            m_valid[i] = 0; m_tag[i] = 0; m_target[i] = '0;
            m_ctr[i] = CTR_HALF - 1;
        end
        m_upd = 0; m_mis = 0;
    endtask

    task automatic m_train(input logic [31:0] pc, input bit jmp, input bit tk,
                           input logic [31:0] tgt);
        int unsigned i;
        i = idx_of(pc);
        if (m_hit(pc)) begin
            if (jmp)     m_ctr[i] = CTR_TOP;
            else if (tk) m_ctr[i] = (m_ctr[i] < CTR_TOP) ? m_ctr[i] + 1 : CTR_TOP;
            else         m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
            if (tk) m_target[i] = tgt;
        end else if (tk) begin
            m_valid[i] = 1; m_tag[i] = tag_of(pc); m_target[i] = tgt;
            m_ctr[i] = jmp ? CTR_TOP : CTR_HALF;
        end
    endtask

    function automatic logic [31:0] rand_pc();
        return 32'($urandom_range(0, 63)) << 2;
    endfunction

    initial begin
        bit          e_mp;
        logic [31:0] e_rd;

        // ---- hand sequence: reset state ----
        idle_inputs();
        rst = 1'b1; if_pc = 32'h40;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset_pred_taken", pred_taken, 1'b0);
        check("reset_pred_next_pc", pred_next_pc, 32'h44);
        check("reset_mispredict", mispredict, 1'b0);
        check("reset_stat_updates", stat_updates, 32'd0);
        check("reset_stat_mispredicts", stat_mispredicts, 32'd0);

        // ---- directed table: comb outputs checked before the edge ----
        //   rst if_pc  uv upc   j tk tgt     ppt pptg     ept enpc    emp erd     su  sm
        add(0, 'h40, 0, 'h00, 0, 0, 'h000, 0, 'h000,   0, 'h044, 0, 'h004,  0, 0);
        add(0, 'h40, 1, 'h40, 0, 1, 'h100, 0, 'h044,   0, 'h044, 1, 'h100,  0, 0);
        add(0, 'h40, 1, 'h40, 0, 1, 'h100, 1, 'h100,   1, 'h100, 0, 'h100,  1, 1);
        add(0, 'h40, 1, 'h40, 0, 0, 'h000, 1, 'h100,   1, 'h100, 1, 'h044,  2, 1);
        add(0, 'h40, 1, 'h40, 0, 0, 'h000, 1, 'h100,   1, 'h100, 1, 'h044,  3, 2);
        add(0, 'h40, 0, 'h00, 0, 0, 'h000, 0, 'h000,   0, 'h044, 0, 'h004,  4, 3);
        add(0, 'h80, 1, 'h80, 0, 1, 'h200, 0, 'h084,   0, 'h084, 1, 'h200,  4, 3);
        add(0, 'h80, 0, 'h00, 0, 0, 'h000, 0, 'h000,   1, 'h200, 0, 'h004,  5, 4);
        add(0, 'h40, 0, 'h00, 0, 0, 'h000, 0, 'h000,   0, 'h044, 0, 'h004,  5, 4);
        add(0, 'h10, 1, 'h10, 0, 0, 'h000, 0, 'h014,   0, 'h014, 0, 'h014,  5, 4);
        add(0, 'h10, 0, 'h00, 0, 0, 'h000, 0, 'h000,   0, 'h014, 0, 'h004,  6, 4);
        add(0, 'h10, 1, 'h10, 1, 1, 'h300, 0, 'h014,   0, 'h014, 1, 'h300,  6, 4);
        add(0, 'h10, 1, 'h10, 1, 1, 'h300, 1, 'h300,   1, 'h300, 0, 'h300,  7, 5);
        add(0, 'h10, 1, 'h10, 0, 1, 'h340, 1, 'h300,   1, 'h300, 1, 'h340,  8, 5);
        add(0, 'h10, 0, 'h00, 0, 0, 'h000, 0, 'h000,   1, 'h340, 0, 'h004,  9, 6);
        add(0, 'h80, 1, 'h80, 0, 0, 'h000, 1, 'h200,   1, 'h200, 1, 'h084,  9, 6);
        add(0, 'h80, 1, 'h80, 0, 0, 'h000, 0, 'h084,   0, 'h084, 0, 'h084, 10, 7);
        add(0, 'h80, 1, 'h80, 0, 0, 'h000, 0, 'h084,   0, 'h084, 0, 'h084, 11, 7);
        add(0, 'h80, 1, 'h80, 0, 1, 'h200, 0, 'h084,   0, 'h084, 1, 'h200, 12, 7);
        add(0, 'h80, 0, 'h00, 0, 0, 'h000, 0, 'h000,   0, 'h084, 0, 'h004, 13, 8);
        add(1, 'h20, 1, 'h20, 0, 1, 'h400, 1, 'h400,   0, 'h024, 0, 'h400, 13, 8);
        add(0, 'h20, 0, 'h00, 0, 0, 'h000, 0, 'h000,   0, 'h024, 0, 'h004,  0, 0);
        add(0, 'h10, 0, 'h00, 0, 0, 'h000, 0, 'h000,   0, 'h014, 0, 'h004,  0, 0);

        foreach (vecs[k]) begin
            @(negedge clk);
            rst = vecs[k].rst; if_pc = vecs[k].if_pc; upd_valid = vecs[k].uv;
            upd_pc = vecs[k].upc; upd_is_jump = vecs[k].jmp;
            upd_taken = vecs[k].tk; upd_target = vecs[k].tgt;
            upd_pred_taken = vecs[k].ppt; upd_pred_target = vecs[k].pptg;
            #1;
            check($sformatf("vec%0d_pred_taken", k), pred_taken, vecs[k].e_pt);
            check($sformatf("vec%0d_pred_next_pc", k), pred_next_pc, vecs[k].e_npc);
            check($sformatf("vec%0d_mispredict", k), mispredict, vecs[k].e_mp);
            check($sformatf("vec%0d_redirect_pc", k), redirect_pc, vecs[k].e_rd);
            check($sformatf("vec%0d_stat_updates", k), stat_updates, vecs[k].e_su);
            check($sformatf("vec%0d_stat_mispredicts", k), stat_mispredicts, vecs[k].e_sm);
        end

        // ---- randomized phase against the reference model ----
        @(negedge clk);
        idle_inputs();
        rst = 1'b1;
        @(posedge clk);
        m_reset();
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            rst         = ($urandom_range(0, 79) == 0);
            if_pc       = rand_pc();
            upd_valid   = ($urandom_range(0, 3) != 0);
            upd_pc      = rand_pc();
            upd_is_jump = ($urandom_range(0, 3) == 0);
            upd_taken   = upd_is_jump ? 1'b1 : 1'($urandom_range(0, 1));
            upd_target  = 32'h1000 + (32'($urandom_range(0, 3)) << 4);
            if ($urandom_range(0, 2) != 0) begin
                upd_pred_taken  = m_pred_taken(upd_pc);
                upd_pred_target = m_pred_pc(upd_pc);
            end else begin
                upd_pred_taken  = 1'($urandom_range(0, 1));
                upd_pred_target = 32'h1000 + (32'($urandom_range(0, 3)) << 4);
            end
            #1;
            e_mp = upd_valid && ((upd_pred_taken != upd_taken) ||
                                 (upd_taken && (upd_pred_target != upd_target)));
            e_rd = upd_taken ? upd_target : upd_pc + 32'd4;
            check("rnd_pred_taken", pred_taken, m_pred_taken(if_pc));
            check("rnd_pred_next_pc", pred_next_pc, m_pred_pc(if_pc));
            check("rnd_mispredict", mispredict, e_mp);
            check("rnd_redirect_pc", redirect_pc, e_rd);
            check("rnd_stat_updates", stat_updates, m_upd[31:0]);
            check("rnd_stat_mispredicts", stat_mispredicts, m_mis[31:0]);
            @(posedge clk);
            if (rst) begin
                m_reset();
            end else begin
                if (upd_valid) begin
                    m_train(upd_pc, upd_is_jump, upd_taken, upd_target);
                    if (m_upd < 64'hFFFF_FFFF) m_upd++;
                end
                if (e_mp && (m_mis < 64'hFFFF_FFFF)) m_mis++;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
